// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG_WIDTH-bit segment per
// stage, carry handed stage to stage through registers, valid/ready flow
// control with bubble collapse.
module pipelined_ripple_adder #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned SEG_WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned STAGES = (SEG_WIDTH == 0 || (WIDTH / SEG_WIDTH) == 0)
                                   ? 1 : WIDTH / SEG_WIDTH;
  localparam int unsigned LAST   = STAGES - 1;
  localparam int unsigned MSB    = WIDTH - 1;

  // Reject configurations where the operand does not split evenly into segments
  generate
    if (WIDTH == 0 || SEG_WIDTH == 0 || (WIDTH % SEG_WIDTH) != 0) begin : g_bad_cfg
      $error("pipelined_ripple_adder: WIDTH must be a nonzero multiple of SEG_WIDTH");
    end
  endgenerate

  // Per-stage state: operands travel whole so each stage can pick its segment
  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic             r_sub [STAGES];
  logic             r_cy  [STAGES];
  logic             r_ovf;

  // Next-state values presented to each stage
  logic             w_load [STAGES];
  logic             w_nvld [STAGES];
  logic [WIDTH-1:0] w_nsum [STAGES];
  logic [WIDTH-1:0] w_na   [STAGES];
  logic [WIDTH-1:0] w_nb   [STAGES];
  logic             w_nsub [STAGES];
  logic             w_ncy  [STAGES];
  logic             w_nov;

  // Load chain: a stage accepts when empty or when its occupant moves on
  always_comb begin
    for (int k = 0; k < STAGES; k++) w_load[k] = 1'b0;
    w_load[LAST] = !r_vld[LAST] || out_ready;
    for (int k = int'(LAST) - 1; k >= 0; k--) begin
      w_load[k] = !r_vld[k] || w_load[k+1];
    end
  end

  assign in_ready = w_load[0];

  // Segment adders; stage 0 takes the ports, later stages their predecessor
  always_comb begin : p_datapath
    logic [SEG_WIDTH:0]   v_add;
    logic [SEG_WIDTH-1:0] v_b;
    v_add = '0;
    v_b   = '0;
    w_nov = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      w_nvld[k] = 1'b0;
      w_nsum[k] = '0;
      w_na[k]   = '0;
      w_nb[k]   = '0;
      w_nsub[k] = 1'b0;
      w_ncy[k]  = 1'b0;
    end

    v_b   = sub ? ~b[SEG_WIDTH-1:0] : b[SEG_WIDTH-1:0];
    v_add = {1'b0, a[SEG_WIDTH-1:0]} + {1'b0, v_b} + (SEG_WIDTH+1)'(sub | carry_in);
    w_nvld[0] = in_valid;
    w_na[0]   = a;
    w_nb[0]   = b;
    w_nsub[0] = sub;
    w_nsum[0][SEG_WIDTH-1:0] = v_add[SEG_WIDTH-1:0];
    w_ncy[0]  = v_add[SEG_WIDTH];

    for (int k = 1; k < STAGES; k++) begin
      v_b   = r_sub[k-1] ? ~r_b[k-1][k*SEG_WIDTH +: SEG_WIDTH]
                         :  r_b[k-1][k*SEG_WIDTH +: SEG_WIDTH];
      v_add = {1'b0, r_a[k-1][k*SEG_WIDTH +: SEG_WIDTH]} + {1'b0, v_b}
              + (SEG_WIDTH+1)'(r_cy[k-1]);
      w_nvld[k] = r_vld[k-1];
      w_na[k]   = r_a[k-1];
      w_nb[k]   = r_b[k-1];
      w_nsub[k] = r_sub[k-1];
      w_nsum[k] = r_sum[k-1];
      w_nsum[k][k*SEG_WIDTH +: SEG_WIDTH] = v_add[SEG_WIDTH-1:0];
      w_ncy[k]  = v_add[SEG_WIDTH];
    end

    w_nov = (w_na[LAST][MSB] == (w_nb[LAST][MSB] ^ w_nsub[LAST]))
            && (w_nsum[LAST][MSB] != w_na[LAST][MSB]);
  end

  // Stage registers, cleared asynchronously so in-flight work is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_sum[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sub[k] <= 1'b0;
        r_cy[k]  <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_vld[k] <= w_nvld[k];
          r_sum[k] <= w_nsum[k];
          r_a[k]   <= w_na[k];
          r_b[k]   <= w_nb[k];
          r_sub[k] <= w_nsub[k];
          r_cy[k]  <= w_ncy[k];
        end
      end
      if (w_load[LAST]) r_ovf <= w_nov;
    end
  end

  assign out_valid = r_vld[LAST];
  assign sum       = r_sum[LAST];
  assign carry_out = r_cy[LAST];
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboarded bench for pipelined_ripple_adder (24/6 main instance, 6/6 single-stage instance).
module tb_pipelined_ripple_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, carry_in, sub, out_valid, out_ready, carry_out, overflow;
  logic [23:0] a, b, sum;

  logic        s_in_valid, s_in_ready, s_out_valid, s_carry_out, s_overflow;
  logic [5:0]  s_a, s_b, s_sum;

  int errors = 0;
  int checks = 0;
  int n_emit = 0;
  logic [25:0] sb[$];
  logic [23:0] last_sum;
  logic        last_cout, last_ovf;

  always #5 clk = ~clk;

  pipelined_ripple_adder #(.WIDTH(24), .SEG_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow));

  pipelined_ripple_adder #(.WIDTH(6), .SEG_WIDTH(6)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .carry_in(1'b0), .sub(1'b0),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .sum(s_sum), .carry_out(s_carry_out), .overflow(s_overflow));

  // Reference: {carry_out, overflow, sum}
  function automatic logic [25:0] model(input logic [23:0] ia, input logic [23:0] ib,
                                        input logic ic, input logic is);
    logic [23:0] eb;
    logic [24:0] t;
    eb = is ? ~ib : ib;
    t  = {1'b0, ia} + {1'b0, eb} + 25'(is ? 1'b1 : ic);
    return {t[24], (ia[23] == eb[23]) && (t[23] != ia[23]), t[23:0]};
  endfunction

  // Transfers are decided by values stable from negedge+3 to the next posedge
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        logic [25:0] e;
        checks++;
        n_emit++;
        last_sum = sum; last_cout = carry_out; last_ovf = overflow;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_output got sum=%h cout=%b ovf=%b", sum, carry_out, overflow);
        end else begin
          e = sb.pop_front();
          if ({carry_out, overflow, sum} !== e) begin
            errors++;
            $display("FAIL sb_result got cout=%b ovf=%b sum=%h want cout=%b ovf=%b sum=%h",
                     carry_out, overflow, sum, e[25], e[24], e[23:0]);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, carry_in, sub));
    end
  end

  // Present one operand set (entry/exit at negedge) until accepted
  task automatic send(input logic [23:0] ia, input logic [23:0] ib, input logic ic, input logic is);
    int n = 0;
    in_valid = 1'b1; a = ia; b = ib; carry_in = ic; sub = is;
    #1;
    while (!in_ready && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (!(sb.size() == 0 && !out_valid) && n < 40) begin
      @(negedge clk); #4; n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d out_valid=%b want 0 0", sb.size(), out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, carry_out, overflow, sum} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b c=%b o=%b sum=%h want all 0", out_valid, carry_out, overflow, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_carry_wrap();
    int cyc;
    in_valid = 1'b1; a = 24'hFFFFFF; b = 24'h000001; carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL first_accept_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc != 4) begin
      errors++; $display("FAIL latency got %0d want 4", cyc);
    end
    @(negedge clk);
    drain();
    checks++;
    if ({last_cout, last_ovf, last_sum} !== {1'b1, 1'b0, 24'h000000}) begin
      errors++; $display("FAIL carry_wrap got c=%b o=%b sum=%h want 1 0 000000", last_cout, last_ovf, last_sum);
    end
  endtask

  task automatic test_sub_overflow();
    send(24'h000005, 24'h000007, 1'b1, 1'b1);
    drain();
    checks++;
    if ({last_cout, last_ovf, last_sum} !== {1'b0, 1'b0, 24'hFFFFFE}) begin
      errors++; $display("FAIL sub_neg got c=%b o=%b sum=%h want 0 0 fffffe", last_cout, last_ovf, last_sum);
    end
    send(24'h7FFFFF, 24'h000001, 1'b0, 1'b0);
    drain();
    checks++;
    if ({last_cout, last_ovf, last_sum} !== {1'b0, 1'b1, 24'h800000}) begin
      errors++; $display("FAIL add_ovf got c=%b o=%b sum=%h want 0 1 800000", last_cout, last_ovf, last_sum);
    end
    send(24'h800000, 24'h000001, 1'b0, 1'b1);
    drain();
    checks++;
    if ({last_cout, last_ovf, last_sum} !== {1'b1, 1'b1, 24'h7FFFFF}) begin
      errors++; $display("FAIL sub_ovf got c=%b o=%b sum=%h want 1 1 7fffff", last_cout, last_ovf, last_sum);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int emit0 = n_emit;
    int n = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; a = 24'(idx + 1); b = '0; carry_in = 1'b0; sub = 1'b0;
      #1;
      if (in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b1; a = 24'(idx + 1);
    #1;
    checks++;
    if (idx != 4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_occupancy got accepted=%0d in_ready=%b want 4 0", idx, in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || sum !== 24'd1) begin
      errors++; $display("FAIL bp_head got v=%b sum=%h want 1 000001", out_valid, sum);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sum !== 24'd1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold got v=%b sum=%h want 1 000001", out_valid, sum);
    end
    @(negedge clk);
    out_ready = 1'b1;
    while (idx < 6 && n < 20) begin
      in_valid = 1'b1; a = 24'(idx + 1);
      #1;
      if (in_ready) idx++;
      @(negedge clk); n++;
    end
    drain();
    checks++;
    if (n_emit - emit0 != 6 || last_sum !== 24'd6) begin
      errors++; $display("FAIL bp_emitted got %0d last=%h want 6 000006", n_emit - emit0, last_sum);
    end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    int emit0 = n_emit;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b1; a = 24'($urandom); b = 24'($urandom);
      carry_in = 1'($urandom); sub = 1'($urandom);
      #1;
      if (!in_ready) stalls++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (stalls != 0) begin
      errors++; $display("FAIL b2b_stalls got %0d want 0", stalls);
    end
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      a = 24'($urandom); b = 24'($urandom); carry_in = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    drain();
    checks++;
    if (n_emit - emit0 < 24) begin
      errors++; $display("FAIL b2b_count got %0d want >=24", n_emit - emit0);
    end
  endtask

  task automatic test_reset_flight();
    int n = 0;
    int seen = 0;
    out_ready = 1'b0;
    send(24'h7FFFFF, 24'hFFFFFF, 1'b0, 1'b0);
    send(24'h000003, 24'h000004, 1'b0, 1'b0);
    while (!out_valid && n < 10) begin
      @(negedge clk); n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, carry_out, overflow, sum} !== 27'd0) begin
      errors++;
      $display("FAIL async_reset got v=%b c=%b o=%b sum=%h want all 0", out_valid, carry_out, overflow, sum);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL stale_after_reset got %0d valid cycles want 0", seen);
    end
    send(24'h000001, 24'h000002, 1'b0, 1'b0);
    drain();
    checks++;
    if (last_sum !== 24'h000003) begin
      errors++; $display("FAIL post_reset_sum got %h want 000003", last_sum);
    end
  endtask

  task automatic test_single_stage();
    s_in_valid = 1'b1; s_a = 6'd63; s_b = 6'd1;
    #1;
    checks++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
      errors++; $display("FAIL small_idle got rdy=%b v=%b want 1 0", s_in_ready, s_out_valid);
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    checks++;
    if (s_out_valid !== 1'b1 || s_sum !== 6'd0 || s_carry_out !== 1'b1 || s_overflow !== 1'b0) begin
      errors++;
      $display("FAIL small_result got v=%b sum=%h c=%b o=%b want 1 00 1 0", s_out_valid, s_sum, s_carry_out, s_overflow);
    end
    @(posedge clk); #1;
    checks++;
    if (s_out_valid !== 1'b0) begin
      errors++; $display("FAIL small_single_emit got v=%b want 0", s_out_valid);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_carry_wrap();
    test_sub_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_flight();
    test_single_stage();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
